// File: rtl/mem_arbiter.sv
// mem_arbiter: registered I/D cache to single-RAM arbiter with D priority and I starvation guard
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ramready
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] DGNT = 3'd1;
    localparam logic [2:0] IGNT = 3'd2;
    localparam logic [2:0] DRSP = 3'd3;
    localparam logic [2:0] IRSP = 3'd4;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [2:0]        state, nextState;
    logic [3:0]        starveCnt;
    logic [ADDR_W-1:0] latAddr;
    logic [DATA_W-1:0] latStore, rspData;
    logic              latWrite;
    logic              dReq, dGo, iGo, capture;

    always_comb begin
        dReq      = dREN | dWEN;
        dGo       = dReq && (!iREN || starveCnt < STARVE_LIM);
        iGo       = iREN && !dGo;
        capture   = ramready && ((state == DGNT && dReq) || (state == IGNT && iREN));
        nextState = IDLE;
        case (state)
            IDLE:    nextState = dGo ? DGNT : (iGo ? IGNT : IDLE);
            DGNT:    nextState = !dReq ? IDLE : (ramready ? DRSP : DGNT);
            IGNT:    nextState = !iREN ? IDLE : (ramready ? IRSP : IGNT);
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            starveCnt <= 4'd0;
            latAddr   <= '0;
            latStore  <= '0;
            latWrite  <= 1'b0;
            rspData   <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE) begin
                // starvation only accumulates while I is actually waiting behind D
                starveCnt <= (!iREN || iGo) ? 4'd0 :
                             (starveCnt != 4'hF ? starveCnt + 4'd1 : starveCnt);
                if (dGo) begin
                    latAddr  <= daddr;
                    latStore <= dstore;
                    latWrite <= dWEN;
                end else if (iGo) begin
                    latAddr  <= iaddr;
                    latWrite <= 1'b0;
                end
            end
            if (capture)
                rspData <= ramload;
        end
    end

    assign ramREN   = (state == DGNT && !latWrite) || state == IGNT;
    assign ramWEN   = state == DGNT && latWrite;
    assign ramaddr  = latAddr;
    assign ramstore = latStore;
    assign dwait    = state != DRSP;
    assign iwait    = state != IRSP;
    assign dload    = rspData;
    assign iload    = rspData;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ramready = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramloadReg = '0;
    logic        useModel = 1'b0;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    int          checks = 0;
    int          failures = 0;

    assign ramload = useModel ? (ramaddr ^ 32'hA5A5_0000) : ramloadReg;

    mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        tick;
        checks++; if ({iwait, dwait} !== 2'b11) begin failures++; $display("FAIL reset_waits: got %b want 11", {iwait, dwait}); end
        checks++; if ({ramREN, ramWEN} !== 2'b00) begin failures++; $display("FAIL reset_strobes: got %b want 00", {ramREN, ramWEN}); end
        checks++; if ({iload, dload, ramaddr, ramstore} !== 128'd0) begin failures++; $display("FAIL reset_data: got %h want 0", {iload, dload, ramaddr, ramstore}); end
        RST = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_grant;
        dWEN = 1'b1; daddr = 32'h40; dstore = 32'h55;
        tick;
        checks++; if (ramWEN !== 1'b1) begin failures++; $display("FAIL midrst_wen_before: got %b want 1", ramWEN); end
        #2 RST = 1'b1;
        #1;
        checks++; if (ramWEN !== 1'b0) begin failures++; $display("FAIL midrst_wen_async: got %b want 0", ramWEN); end
        dWEN = 1'b0;
        tick;
        RST = 1'b0;
        checks++; if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) begin failures++; $display("FAIL midrst_ctrl: got %b want 0011", {ramREN, ramWEN, iwait, dwait}); end
        checks++; if ({dload, ramaddr, ramstore} !== 96'd0) begin failures++; $display("FAIL midrst_data: got %h want 0", {dload, ramaddr, ramstore}); end
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++; if (dwait !== 1'b1) begin failures++; $display("FAIL midrst_dwait_%0d: got %b want 1", k, dwait); end
        end
    endtask

    task automatic test_d_read;
        dREN = 1'b1; daddr = 32'h100;
        for (int c = 1; c <= 3; c++) begin
            tick;
            checks++; if ({ramREN, ramWEN} !== 2'b10 || ramaddr !== 32'h100) begin failures++; $display("FAIL dread_strobe_c%0d: got ren=%b wen=%b addr=%h want 1 0 100", c, ramREN, ramWEN, ramaddr); end
            checks++; if ({dwait, iwait} !== 2'b11) begin failures++; $display("FAIL dread_wait_c%0d: got %b want 11", c, {dwait, iwait}); end
        end
        ramready = 1'b1; ramloadReg = 32'hDEADBEEF;
        tick;
        ramready = 1'b0;
        checks++; if (dwait !== 1'b0 || dload !== 32'hDEADBEEF) begin failures++; $display("FAIL dread_rsp: got dwait=%b dload=%h want 0 deadbeef", dwait, dload); end
        checks++; if ({iwait, ramREN, ramWEN} !== 3'b100) begin failures++; $display("FAIL dread_rsp_ctrl: got %b want 100", {iwait, ramREN, ramWEN}); end
        dREN = 1'b0;
        tick;
        checks++; if (dwait !== 1'b1) begin failures++; $display("FAIL dread_after: got %b want 1", dwait); end
    endtask

    task automatic test_d_write;
        int pulses = 0;
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h3100; dstore = 32'h7;
        tick;
        checks++; if ({ramWEN, ramREN} !== 2'b10 || ramstore !== 32'h7 || ramaddr !== 32'h3100) begin failures++; $display("FAIL dwrite_strobe: got wen=%b ren=%b store=%h addr=%h want 1 0 7 3100", ramWEN, ramREN, ramstore, ramaddr); end
        ramready = 1'b1;
        tick;
        ramready = 1'b0; dWEN = 1'b0; dREN = 1'b0;
        if (dwait === 1'b0) pulses++;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (dwait === 1'b0) pulses++;
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL dwrite_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_starvation;
        string expOrder = "DDDDIDDDDI";
        byte   got;
        int    n = 0;
        useModel = 1'b1; ramready = 1'b1;
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h300;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            tick;
            checks++; if (!dwait && !iwait || ramREN && ramWEN) begin failures++; $display("FAIL starve_excl: got waits=%b%b strobes=%b%b", dwait, iwait, ramREN, ramWEN); end
            if (!dwait || !iwait) begin
                got = !dwait ? "D" : "I";
                checks++; if (got != expOrder[n]) begin failures++; $display("FAIL starve_order_%0d: got %c want %c", n, got, expOrder[n]); end
                if (got == "I") begin
                    checks++; if (iload !== (32'h200 ^ 32'hA5A5_0000)) begin failures++; $display("FAIL starve_iload_%0d: got %h want %h", n, iload, 32'h200 ^ 32'hA5A5_0000); end
                end
                n++;
            end
        end
        checks++; if (n != 10) begin failures++; $display("FAIL starve_timeout: got %0d responses want 10", n); end
        iREN = 1'b0; dREN = 1'b0; ramready = 1'b0; useModel = 1'b0;
        tick; tick; tick;
    endtask

    task automatic test_abort;
        iREN = 1'b1; iaddr = 32'h200; dREN = 1'b1; daddr = 32'h500;
        tick;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin failures++; $display("FAIL abort_grant: got ren=%b addr=%h want 1 500", ramREN, ramaddr); end
        tick;
        dREN = 1'b0; ramready = 1'b1; ramloadReg = 32'hBAD0BAD0;
        tick;
        ramready = 1'b0;
        checks++; if ({ramREN, dwait, iwait} !== 3'b011) begin failures++; $display("FAIL abort_idle: got %b want 011", {ramREN, dwait, iwait}); end
        tick;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h200 || dwait !== 1'b1) begin failures++; $display("FAIL abort_igrant: got ren=%b addr=%h dwait=%b want 1 200 1", ramREN, ramaddr, dwait); end
        ramready = 1'b1; ramloadReg = 32'h12345678;
        tick;
        ramready = 1'b0; iREN = 1'b0;
        checks++; if (iwait !== 1'b0 || iload !== 32'h12345678 || dwait !== 1'b1) begin failures++; $display("FAIL abort_irsp: got iwait=%b iload=%h dwait=%b want 0 12345678 1", iwait, iload, dwait); end
        tick;
    endtask

    task automatic test_back_to_back;
        dREN = 1'b1; daddr = 32'h600;
        tick;
        ramready = 1'b1; ramloadReg = 32'h11;
        tick;
        ramready = 1'b0;
        checks++; if (dwait !== 1'b0 || dload !== 32'h11) begin failures++; $display("FAIL b2b_rsp1: got dwait=%b dload=%h want 0 11", dwait, dload); end
        daddr = 32'h700;
        #1;
        checks++; if (ramaddr !== 32'h600 || ramREN !== 1'b0) begin failures++; $display("FAIL b2b_rsp_addr: got addr=%h ren=%b want 600 0", ramaddr, ramREN); end
        tick;
        checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin failures++; $display("FAIL b2b_idle: got ren=%b dwait=%b want 0 1", ramREN, dwait); end
        ramready = 1'b1; ramloadReg = 32'h22;
        tick;
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h700 || dwait !== 1'b1) begin failures++; $display("FAIL b2b_grant2: got ren=%b addr=%h dwait=%b want 1 700 1", ramREN, ramaddr, dwait); end
        ramloadReg = 32'h33;
        tick;
        ramready = 1'b0; dREN = 1'b0;
        checks++; if (dwait !== 1'b0 || dload !== 32'h33) begin failures++; $display("FAIL b2b_rsp2: got dwait=%b dload=%h want 0 33", dwait, dload); end
        tick;
        checks++; if (dwait !== 1'b1) begin failures++; $display("FAIL b2b_end: got %b want 1", dwait); end
    endtask

    initial begin
        test_reset;
        test_reset_mid_grant;
        test_d_read;
        test_d_write;
        test_starvation;
        test_abort;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Registered two-port memory arbiter that sits directly downstream of the instruction and data caches. It accepts one word request at a time from either cache and drives the single RAM port. It returns the read data or write completion to the requester with a one-cycle response pulse. Data-cache requests have priority, and a starvation counter guarantees instruction-fetch progress.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width
- STARVE_MAX, 4, consecutive D grants allowed while I is pending before I is forced; 1..15

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; one clock, asynchronous, active-high
- iREN  in  1  instruction cache read request
- iaddr  in  ADDR_W  instruction word address
- iwait  out  1  low for exactly one cycle when the I read completes
- iload  out  DATA_W  I read data, valid while iwait=0
- dREN  in  1  data cache read request
- dWEN  in  1  data cache write request; dominates dREN if both are high
- daddr  in  ADDR_W  data word address
- dstore  in  DATA_W  write data
- dwait  out  1  low for exactly one cycle when the D access completes
- dload  out  DATA_W  D read data, valid while dwait=0
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data, valid when ramready=1
- ramready  in  1  RAM completes the current access this cycle

## Operation
- States: IDLE, DGNT, IGNT, DRSP, IRSP.
- IDLE: arbitrate among the live requests (dREN|dWEN, iREN).
  - D only -> DGNT. I only -> IGNT.
  - Both live: if starve_cnt >= STARVE_MAX -> IGNT; else -> DGNT.
  - No request -> stay in IDLE.
- Latching: on entry to a grant state, latch the address, op (write if dWEN) and store data into internal registers. RAM outputs come only from these registers and the state; they never come combinationally from the requester.
- DGNT / IGNT:
  - Assert ramREN or ramWEN per the latched op.
  - On ramready: capture ramload into the response register, then go to DRSP / IRSP.
  - Abort: if the granted requester drops all of its request lines, go to IDLE next cycle with no response pulse and no data capture. RAM strobes deassert in that cycle.
- DRSP / IRSP:
  - dwait / iwait = 0 and dload / iload = captured data, for one cycle.
  - RAM strobes are 0.
  - Unconditionally go to IDLE. Requests present during this cycle are not evaluated until the IDLE cycle.
- starve_cnt (4-bit):
  - Increments on each IDLE->DGNT transition taken while iREN=1.
  - Clears on any IDLE->IGNT transition, and whenever iREN=0 in IDLE.
  - Saturates at 15.
- Writes: dload in DRSP is the captured ramload and is don't-care for the cache. ramstore holds the latched dstore for the whole grant.
- Waits:
  - dwait=1 in every state except DRSP; iwait=1 in every state except IRSP.
  - A requester must hold its request and address stable until its wait drops.

## Timing
- Reset: state=IDLE, starve_cnt=0, latched registers=0.
  - iwait=1, dwait=1, iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Latency: request at cycle 0 (IDLE) -> grant and RAM strobe at cycle 1.
  - Earliest ramready is cycle 1 -> response (wait low) at cycle 2 -> IDLE at cycle 3.
  - Minimum 3-cycle issue interval per port.
- ramready sampled outside DGNT / IGNT is ignored.
- ramready in the same cycle the requester drops: abort takes precedence; no response.
- RST asserted mid-grant: RAM strobes drop immediately (asynchronous); no response is ever issued for that request.
- Both waits are never low in the same cycle. At most one RAM strobe is high at any time.

## Test plan
- Reset mid-DGNT (write to 0x40 in progress): ramWEN falls asynchronously with RST; after release the block is in IDLE with all outputs at reset values, and dwait stays high until a new request.
- Single D read: daddr=0x100, dREN=1, RAM returns 0xDEADBEEF with ramready at cycle 3.
  - ramREN=1 and ramaddr=0x100 for cycles 1-3.
  - dwait=0 and dload=0xDEADBEEF at cycle 4 only.
  - iwait=1 throughout.
- D write with both strobes: dWEN=dREN=1, daddr=0x3100, dstore=0x7: ramWEN=1, ramREN=0, ramstore=0x7; dwait pulses low once after ramready.
- Simultaneous requests, STARVE_MAX=4: iREN and the D requester held continuously, ramready=1 every cycle.
  - Grant order is D,D,D,D,I,D,D,D,D,I.
  - iload equals the RAM data for iaddr on each IRSP.
- Abort: D read granted, dREN dropped on cycle 2 with ramready=1 on cycle 2.
  - No dwait pulse; ramREN=0 on cycle 3.
  - A pending iREN is granted from the following IDLE.
- Back-to-back D: the requester raises a new address in the DRSP cycle; the new grant appears two cycles after DRSP, and ramaddr is never the new address during DRSP.
